// File: rtl/skolem_sweep_ctrl_pkg.sv
// Shared types and default widths for the Skolem sweep controller.
`default_nettype none

package skolem_chk_pkg;

  localparam int NX_DEF = 8;
  localparam int NY_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    CHECK  = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/skolem_sweep_ctrl_if.sv
// Sweep-controller bus: request/abort, universal-input drive, verdict and results.
`default_nettype none

interface skolem_sweep_ctrl_if
  import skolem_chk_pkg::*;
#(
  parameter int NX = NX_DEF,
  parameter int NY = NY_DEF
);

  logic          start;
  logic          abort;
  logic [NX-1:0] x_out;
  logic [NY-1:0] y_in;
  logic          spec_ok;
  logic          busy;
  logic          done;
  logic          pass;
  logic [NX:0]   fail_cnt;
  logic          first_fail_vld;
  logic [NX-1:0] first_fail_x;
  logic [NY-1:0] first_fail_y;

  // Sweep controller side.
  modport slave (
    input  start, abort, y_in, spec_ok,
    output x_out, busy, done, pass, fail_cnt,
           first_fail_vld, first_fail_x, first_fail_y
  );

  // Requester plus Skolem block and spec checker side.
  modport master (
    output start, abort, y_in, spec_ok,
    input  x_out, busy, done, pass, fail_cnt,
           first_fail_vld, first_fail_x, first_fail_y
  );

endinterface

`default_nettype wire

// File: rtl/skolem_sweep_ctrl_fail_capture.sv
// Failure counter and first-failing-vector capture.
`default_nettype none

module skolem_fail_capture #(
  parameter int NX = 8,
  parameter int NY = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          sample_en,
  input  wire logic          fail,
  input  wire logic [NX-1:0] x,
  input  wire logic [NY-1:0] y,
  input  wire logic          clear,
  output logic [NX:0]        fail_cnt,
  output logic               first_fail_vld,
  output logic [NX-1:0]      first_fail_x,
  output logic [NY-1:0]      first_fail_y
);

  logic [NX:0]   r_cnt;
  logic          r_vld;
  logic [NX-1:0] r_x;
  logic [NY-1:0] r_y;

  // Counter is NX+1 bits wide, so 2^NX failures cannot overflow it.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
      r_vld <= 1'b0;
      r_x   <= '0;
      r_y   <= '0;
    end else if (sample_en && fail) begin
      r_cnt <= r_cnt + 1'b1;
      if (!r_vld) begin
        r_vld <= 1'b1;
        r_x   <= x;
        r_y   <= y;
      end
    end
  end

  assign fail_cnt       = r_cnt;
  assign first_fail_vld = r_vld;
  assign first_fail_x   = r_x;
  assign first_fail_y   = r_y;

endmodule

`default_nettype wire

// File: rtl/skolem_sweep_ctrl.sv
// Exhaustive sweep of the universal inputs of a Skolem block, counting spec-checker failures.
`default_nettype none

module skolem_sweep_ctrl
  import skolem_chk_pkg::*;
#(
  parameter int NX           = NX_DEF,
  parameter int NY           = NY_DEF,
  parameter int SETTLE       = 1,
  parameter int STOP_ON_FAIL = 0
) (
  input  wire logic            clk,
  input  wire logic            rst,
  skolem_sweep_ctrl_if.slave   bus
);

  localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE - 1);

  state_t        r_state;
  logic [NX-1:0] r_x;
  logic [3:0]    r_settle;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;

  logic          w_accept;
  logic          w_sample;
  logic          w_fail;
  logic          w_last;
  logic [NX:0]   w_fail_cnt;
  logic          w_ff_vld;
  logic [NX-1:0] w_ff_x;
  logic [NY-1:0] w_ff_y;

  assign w_accept = (r_state == IDLE) && bus.start && !bus.abort;
  // An abort in CHECK discards that cycle's verdict.
  assign w_sample = (r_state == CHECK) && !bus.abort;
  assign w_fail   = !bus.spec_ok;
  assign w_last   = &r_x;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_x      <= '0;
      r_settle <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_x      <= '0;
            r_settle <= '0;
            r_busy   <= 1'b1;
            r_pass   <= 1'b0;
            r_state  <= APPLY;
          end
        end
        APPLY: begin
          if (bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_settle == c_SETTLE_LAST) begin
            r_state <= CHECK;
          end else begin
            r_settle <= r_settle + 4'd1;
          end
        end
        CHECK: begin
          if (bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_last || ((STOP_ON_FAIL != 0) && w_fail)) begin
            r_state <= FINISH;
          end else begin
            r_x      <= r_x + 1'b1;
            r_settle <= '0;
            r_state  <= APPLY;
          end
        end
        FINISH: begin
          // fail_cnt already includes the final CHECK sample here.
          r_done  <= 1'b1;
          r_pass  <= (w_fail_cnt == '0);
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  skolem_fail_capture #(
    .NX (NX),
    .NY (NY)
  ) u_fail_capture (
    .clk            (clk),
    .rst            (rst),
    .sample_en      (w_sample),
    .fail           (w_fail),
    .x              (r_x),
    .y              (bus.y_in),
    .clear          (w_accept),
    .fail_cnt       (w_fail_cnt),
    .first_fail_vld (w_ff_vld),
    .first_fail_x   (w_ff_x),
    .first_fail_y   (w_ff_y)
  );

  assign bus.x_out          = r_x;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.pass           = r_pass;
  assign bus.fail_cnt       = w_fail_cnt;
  assign bus.first_fail_vld = w_ff_vld;
  assign bus.first_fail_x   = w_ff_x;
  assign bus.first_fail_y   = w_ff_y;

endmodule

`default_nettype wire
